// File: rtl/range_cnt_pkg.sv
// Shared constants and direction encoding for the bounded up/down load counter.
package range_cnt_pkg;

    localparam int RANGE_CNT_WIDTH = 6;
    localparam int RANGE_CNT_MIN   = 5;
    localparam int RANGE_CNT_MAX   = 40;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/range_cnt_next.sv
// Combinational next-value logic: load clamp, bounded step with wrap, and recovery from out-of-range state.
module range_cnt_next
    import range_cnt_pkg::*;
#(
    parameter int WIDTH     = RANGE_CNT_WIDTH,
    parameter int RANGE_MIN = RANGE_CNT_MIN,
    parameter int RANGE_MAX = RANGE_CNT_MAX
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             u_d,
    output logic [WIDTH-1:0] count_next
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(RANGE_MIN);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(RANGE_MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic out_of_range;

    assign out_of_range = (count < MIN_V) || (count > MAX_V);

    always_comb begin
        count_next = count;
        if (load) begin
            if (data < MIN_V) begin
                count_next = MIN_V;
            end else if (data > MAX_V) begin
                count_next = MAX_V;
            end else begin
                count_next = data;
            end
        end else if (out_of_range) begin
            count_next = MIN_V;
        end else if (u_d == DIR_DOWN) begin
            // An unknown u_d fails this test and falls through to the up branch.
            count_next = (count == MIN_V) ? MAX_V : (count - ONE_V);
        end else begin
            count_next = (count == MAX_V) ? MIN_V : (count + ONE_V);
        end
    end

endmodule

// File: rtl/range_u_d_load_counter.sv
// Bounded up/down counter with clamped parallel load; count register, reset and optional terminal count.
// Define RANGE_CNT_TC_EN to add the tc output (next step will wrap).
module range_u_d_load_counter
    import range_cnt_pkg::*;
#(
    parameter int WIDTH     = RANGE_CNT_WIDTH,
    parameter int RANGE_MIN = RANGE_CNT_MIN,
    parameter int RANGE_MAX = RANGE_CNT_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             u_d,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
`ifdef RANGE_CNT_TC_EN
    output logic             tc,
`endif
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(RANGE_MIN);

    generate
        if (!((RANGE_MIN >= 0) && (RANGE_MIN < RANGE_MAX) && (RANGE_MAX <= (2 ** WIDTH) - 1))) begin : g_bad_range
            $error("range_u_d_load_counter: need 0 <= RANGE_MIN < RANGE_MAX <= 2**WIDTH-1");
        end
    endgenerate

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] step_value;

    range_cnt_next #(
        .WIDTH     (WIDTH),
        .RANGE_MIN (RANGE_MIN),
        .RANGE_MAX (RANGE_MAX)
    ) u_next (
        .count      (count_q),
        .data       (data),
        .load       (load),
        .u_d        (u_d),
        .count_next (step_value)
    );

    always_comb begin
        count_d = step_value;
        if (rst) begin
            count_d = MIN_V;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

`ifdef RANGE_CNT_TC_EN
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(RANGE_MAX);

    logic at_max_q;
    logic at_max_d;
    logic at_min_q;
    logic at_min_d;

    // Bound flags track the value the register will hold, so tc only adds a gate on u_d.
    always_comb begin
        at_max_d = (count_d == MAX_V);
        at_min_d = (count_d == MIN_V);
    end

    always_ff @(posedge clk) begin
        at_max_q <= at_max_d;
        at_min_q <= at_min_d;
    end

    assign tc = !rst && ((at_max_q && (u_d == DIR_UP)) || (at_min_q && (u_d == DIR_DOWN)));
`endif

endmodule

// File: tb/tb_range_u_d_load_counter.sv
// Self-checking bench for range_u_d_load_counter: table of directed vectors plus boundary sequences.
`timescale 1ns/1ps
module tb_range_u_d_load_counter;

    logic       clk;
    logic       rst;
    logic       u_d;
    logic       load;
    logic [5:0] data;
    logic [5:0] count;
`ifdef RANGE_CNT_TC_EN
    logic       tc;
`endif

    int n_checks;
    int n_fails;

    typedef struct {
        logic       rst;
        logic       load;
        logic       u_d;
        logic [5:0] data;
        logic [5:0] exp_count;
        string      name;
    } vec_t;

    vec_t vecs[$];

    range_u_d_load_counter dut (
        .clk   (clk),
        .rst   (rst),
        .u_d   (u_d),
        .load  (load),
        .data  (data),
`ifdef RANGE_CNT_TC_EN
        .tc    (tc),
`endif
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic l, input logic u,
                                input logic [5:0] d, input logic [5:0] e, input string nm);
        vec_t v;
        v.rst = r; v.load = l; v.u_d = u; v.data = d; v.exp_count = e; v.name = nm;
        vecs.push_back(v);
    endfunction

    task automatic check_count(input string nm, input logic [5:0] exp);
        n_checks++;
        if (count !== exp) begin
            n_fails++;
            $display("FAIL %s: count=%0d expected %0d", nm, count, exp);
        end else begin
            $display("ok   %s: count=%0d", nm, count);
        end
    endtask

    task automatic drive_edge(input logic r, input logic l, input logic u, input logic [5:0] d);
        rst = r; load = l; u_d = u; data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; u_d = 1'b1; data = 6'd0;
        n_checks = 0;
        n_fails  = 0;

        // Reset then load
        add(1, 0, 1, 6'd0,  6'd5,  "reset");
        add(0, 1, 1, 6'd22, 6'd22, "load22");
        // Up 8 then down 10
        for (int i = 1; i <= 8; i++)  add(0, 0, 1, 6'd0, 6'(22 + i), "up");
        for (int i = 1; i <= 10; i++) add(0, 0, 0, 6'd0, 6'(30 - i), "down");
        // Wrap up
        add(0, 1, 1, 6'd39, 6'd39, "load39");
        add(0, 0, 1, 6'd0,  6'd40, "up_to_max");
        add(0, 0, 1, 6'd0,  6'd5,  "wrap_up");
        add(0, 0, 1, 6'd0,  6'd6,  "after_wrap_up");
        // Wrap down
        add(0, 1, 0, 6'd6,  6'd6,  "load6");
        add(0, 0, 0, 6'd0,  6'd5,  "down_to_min");
        add(0, 0, 0, 6'd0,  6'd40, "wrap_down");
        add(0, 0, 0, 6'd0,  6'd39, "after_wrap_down");
        // Load clamp and priority
        add(0, 1, 0, 6'd2,  6'd5,  "clamp_low");
        add(0, 1, 0, 6'd63, 6'd40, "clamp_high");
        add(0, 1, 1, 6'd10, 6'd10, "load_beats_step");
        add(0, 1, 1, 6'd4,  6'd5,  "clamp_min_minus1");
        add(0, 1, 1, 6'd41, 6'd40, "clamp_max_plus1");
        add(0, 1, 0, 6'd5,  6'd5,  "load_exact_min");
        add(0, 1, 1, 6'd40, 6'd40, "load_exact_max");
        add(0, 1, 1, 6'd30, 6'd30, "load30");
        add(1, 1, 1, 6'd22, 6'd5,  "rst_beats_load");
        add(0, 1, 1, 6'd22, 6'd22, "load_after_rst");

        foreach (vecs[i]) begin
            drive_edge(vecs[i].rst, vecs[i].load, vecs[i].u_d, vecs[i].data);
            check_count(vecs[i].name, vecs[i].exp_count);
        end

        // Reset held across several edges while direction is down, then first step wraps.
        for (int i = 0; i < 3; i++) begin
            drive_edge(1, 0, 0, 6'd17);
            check_count("rst_hold", 6'd5);
        end
        drive_edge(0, 0, 0, 6'd0);
        check_count("wrap_from_reset", 6'd40);
        drive_edge(0, 0, 1, 6'd0);
        check_count("up_from_max", 6'd5);
        drive_edge(0, 0, 1, 6'd0);
        check_count("up_from_min", 6'd6);

`ifdef RANGE_CNT_TC_EN
        drive_edge(0, 1, 1, 6'd39);
        n_checks++;
        if (tc !== 1'b0) begin n_fails++; $display("FAIL tc_at39: tc=%0b expected 0", tc); end
        drive_edge(0, 0, 1, 6'd0);
        check_count("tc_count40", 6'd40);
        n_checks++;
        if (tc !== 1'b1) begin n_fails++; $display("FAIL tc_at_max_up: tc=%0b expected 1", tc); end
        else $display("ok   tc_at_max_up: tc=1");
        drive_edge(0, 0, 1, 6'd0);
        check_count("tc_count5", 6'd5);
        n_checks++;
        if (tc !== 1'b0) begin n_fails++; $display("FAIL tc_at_min_up: tc=%0b expected 0", tc); end
        else $display("ok   tc_at_min_up: tc=0");
        u_d = 1'b0;
        #1;
        n_checks++;
        if (tc !== 1'b1) begin n_fails++; $display("FAIL tc_at_min_down: tc=%0b expected 1", tc); end
        else $display("ok   tc_at_min_down: tc=1");
        rst = 1'b1;
        #1;
        n_checks++;
        if (tc !== 1'b0) begin n_fails++; $display("FAIL tc_in_reset: tc=%0b expected 0", tc); end
        else $display("ok   tc_in_reset: tc=0");
        rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
